// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency sweep controller.
package dds_pkg;

    localparam int DDS_FCW_W   = 8;
    localparam int DDS_DWELL_W = 16;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_REPEAT = 2'd1;
    localparam logic [1:0] MODE_UPDOWN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Down-counter that flags the last cycle of each dwell period.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DWELL_W = DDS_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);

    logic [DWELL_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expire = (r_cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Sweep sequencer producing the control word for a phase accumulator:
// single, sawtooth-repeat and triangle sweeps with clamped end points.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FCW_W   = DDS_FCW_W,
    parameter int DWELL_W = DDS_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FCW_W-1:0]   cfg_start_fcw,
    input  logic [FCW_W-1:0]   cfg_stop_fcw,
    input  logic [FCW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    output logic [FCW_W-1:0]   fcw,
    output logic               busy,
    output logic               done,
    output logic               dir
);

    state_t             r_state;
    state_t             w_state_nx;
    logic [FCW_W-1:0]   r_fcw;
    logic [FCW_W-1:0]   w_fcw_nx;
    logic               r_dir;
    logic               w_dir_nx;
    logic               r_tgt_stop;
    logic               w_tgt_stop_nx;
    logic [FCW_W-1:0]   r_start;
    logic [FCW_W-1:0]   r_stop;
    logic [FCW_W-1:0]   r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic [1:0]         r_mode;
    logic               w_latch;
    logic               w_load;
    logic               w_expire;
    logic [DWELL_W-1:0] w_load_val;
    logic [FCW_W-1:0]   w_tgt;
    logic [FCW_W-1:0]   w_alt;

    // One step toward tgt, computed one bit wider so it clamps instead of wrapping.
    function automatic logic [FCW_W-1:0] f_step(
        input logic [FCW_W-1:0] cur,
        input logic [FCW_W-1:0] tgt,
        input logic [FCW_W-1:0] stp,
        input logic             up
    );
        logic [FCW_W:0] sum;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, stp};
            if (sum > {1'b0, tgt}) sum = {1'b0, tgt};
        end else begin
            sum = {1'b0, cur} - {1'b0, stp};
            if (sum[FCW_W] || (sum < {1'b0, tgt})) sum = {1'b0, tgt};
        end
        return sum[FCW_W-1:0];
    endfunction

    assign w_tgt      = r_tgt_stop ? r_stop  : r_start;
    assign w_alt      = r_tgt_stop ? r_start : r_stop;
    assign w_load_val = (r_state == ST_IDLE) ? cfg_dwell : r_dwell;

    dds_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .expire   (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fcw      <= '0;
            r_dir      <= 1'b1;
            r_tgt_stop <= 1'b1;
            r_start    <= '0;
            r_stop     <= '0;
            r_step     <= '0;
            r_dwell    <= '0;
            r_mode     <= MODE_SINGLE;
        end else begin
            r_state    <= w_state_nx;
            r_fcw      <= w_fcw_nx;
            r_dir      <= w_dir_nx;
            r_tgt_stop <= w_tgt_stop_nx;
            if (w_latch) begin
                r_start <= cfg_start_fcw;
                r_stop  <= cfg_stop_fcw;
                r_step  <= cfg_step;
                r_dwell <= cfg_dwell;
                r_mode  <= cfg_mode;
            end
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_fcw_nx      = r_fcw;
        w_dir_nx      = r_dir;
        w_tgt_stop_nx = r_tgt_stop;
        w_latch       = 1'b0;
        w_load        = 1'b0;
        if (abort) begin
            w_state_nx = ST_IDLE;
            w_fcw_nx   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_latch       = 1'b1;
                        w_load        = 1'b1;
                        w_fcw_nx      = cfg_start_fcw;
                        w_dir_nx      = (cfg_stop_fcw >= cfg_start_fcw);
                        w_tgt_stop_nx = 1'b1;
                        w_state_nx    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_expire) begin
                        w_load = 1'b1;
                        // A zero step is a fixed tone: never advance, never finish.
                        if (r_step != '0) begin
                            if (r_fcw != w_tgt) begin
                                w_fcw_nx = f_step(r_fcw, w_tgt, r_step, r_dir);
                            end else if (r_mode == MODE_REPEAT) begin
                                w_fcw_nx = r_start;
                            end else if (r_mode == MODE_UPDOWN) begin
                                w_tgt_stop_nx = ~r_tgt_stop;
                                w_dir_nx      = ~r_dir;
                                w_fcw_nx      = f_step(r_fcw, w_alt, r_step, ~r_dir);
                            end else begin
                                w_state_nx = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nx = ST_IDLE;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    assign fcw  = r_fcw;
    assign dir  = r_dir;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule
